// File: rtl/shift_normalizer.sv
// Handshaked leading/trailing-one normalizer producing the normalized word and shift count.
// Define SHIFT_NORM_FAST_EN for single-cycle priority-encoder resolution.
module shift_normalizer #(
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_shift,
    output logic             out_dir,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] work;
    logic [SW-1:0]    cnt;
    logic             dir_q;
    logic             is_zero;
    logic             resolve;
    logic [WIDTH-1:0] res_data;
    logic [SW-1:0]    res_shift;

    assign is_zero  = (work == '0);
    assign in_ready = (state == IDLE);

`ifdef SHIFT_NORM_FAST_EN
    // Priority encode the target one, then shift it home in one step.
    always_comb begin
        res_shift = '0;
        res_data  = '0;
        if (dir_q) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (work[i]) res_shift = SW'(i);
            end
            res_data = work >> res_shift;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (work[i]) res_shift = SW'(WIDTH - 1 - i);
            end
            res_data = work << res_shift;
        end
    end

    assign resolve = 1'b1;
`else
    logic hit;

    assign hit       = dir_q ? work[0] : work[WIDTH-1];
    assign resolve   = is_zero | hit;
    assign res_data  = work;
    assign res_shift = cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid)  state_n = SHIFT;
            SHIFT:   if (resolve)   state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            cnt       <= '0;
            dir_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
            out_dir   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work    <= in_data;
                        cnt     <= '0;
                        dir_q   <= in_dir;
                        out_dir <= in_dir;
                    end
                end
                SHIFT: begin
                    if (is_zero) begin
                        out_zero  <= 1'b1;
                        out_data  <= '0;
                        out_shift <= '0;
                        out_valid <= 1'b1;
                    end else if (resolve) begin
                        out_zero  <= 1'b0;
                        out_data  <= res_data;
                        out_shift <= res_shift;
                        out_valid <= 1'b1;
                    end else begin
                        work <= dir_q ? (work >> 1) : (work << 1);
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed self-checking bench for shift_normalizer (WIDTH=4).
module tb_shift_normalizer;

`ifdef SHIFT_NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_shift;
    logic       out_dir;
    logic       out_zero;

    int errors = 0;
    int checks = 0;

    shift_normalizer #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_shift(out_shift),
        .out_dir  (out_dir),
        .out_zero (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic dir);
        in_data  = d;
        in_dir   = dir;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input logic [3:0] d,
                        input logic dir, input logic [3:0] ed,
                        input logic [1:0] es, input logic ez,
                        input int lat);
        int n;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        send(d, dir);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(n);
        check({tag, "_lat"}, n, FAST ? 32'd1 : lat);
        check({tag, "_data"}, 32'(out_data), 32'(ed));
        check({tag, "_shift"}, 32'(out_shift), 32'(es));
        check({tag, "_zero"}, 32'(out_zero), 32'(ez));
        check({tag, "_dir"}, 32'(out_dir), 32'(dir));
        release_out();
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int         n;
        logic [3:0] w;
        logic [3:0] back;
        logic       tbit;

        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_shift", 32'(out_shift), 32'd0);
        check("rst_dir", 32'(out_dir), 32'd0);
        check("rst_zero", 32'(out_zero), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        xact("left", 4'b0010, 1'b0, 4'b1000, 2'd2, 1'b0, 3);
        xact("right", 4'b1100, 1'b1, 4'b0011, 2'd2, 1'b0, 3);
        xact("right0", 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 1);
        xact("zero", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1);
        xact("left3", 4'b0001, 1'b0, 4'b1000, 2'd3, 1'b0, 4);
        xact("right3", 4'b1000, 1'b1, 4'b0001, 2'd3, 1'b0, 4);

        // Backpressure: hold result while the input side churns.
        send(4'b0010, 1'b0);
        wait_valid(n);
        check("bp_lat", n, FAST ? 32'd1 : 32'd3);
        for (int i = 0; i < 5; i++) begin
            in_data  = 4'($urandom);
            in_dir   = 1'($urandom);
            in_valid = 1'b1;
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h8);
            check("bp_shift", 32'(out_shift), 32'd2);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        in_data   = 4'b0100;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_rel_ready", 32'(in_ready), 32'd1);
        check("bp_rel_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_next_lat", n, FAST ? 32'd1 : 32'd2);
        check("bp_next_data", 32'(out_data), 32'h8);
        check("bp_next_shift", 32'(out_shift), 32'd1);
        release_out();

        // Abort a transaction in flight.
        send(4'b0001, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_data", 32'(out_data), 32'd0);
        check("mid_shift", 32'(out_shift), 32'd0);
        check("mid_zero", 32'(out_zero), 32'd0);
        check("mid_dir", 32'(out_dir), 32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) n++;
        end
        check("mid_no_pulse", n, 32'd0);
        check("mid_idle", 32'(in_ready), 32'd1);

        // Every word, both directions: undoing the shift restores the input.
        for (int v = 0; v < 16; v++) begin
            for (int d = 0; d < 2; d++) begin
                w = 4'(v);
                send(w, d[0]);
                wait_valid(n);
                check("rt_valid", 32'(out_valid), 32'd1);
                back = d[0] ? (out_data << out_shift)
                            : (out_data >> out_shift);
                check("rt_back", 32'(back), 32'(w));
                check("rt_zero", 32'(out_zero), 32'(w == 4'd0));
                tbit = d[0] ? out_data[0] : out_data[3];
                check("rt_norm", 32'(tbit), 32'(w != 4'd0));
                check("rt_dir", 32'(out_dir), 32'(d[0]));
                release_out();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Handshaked normalizer that finds the shift needed to bring the leading one to the MSB (left mode) or the trailing one to the LSB (right mode). It outputs the normalized word and the shift count. It is the inverse of the datapath's registered barrel shifter: `out_data` shifted by `out_shift` in the opposite direction reproduces `in_data`, with zeros filled in. It sits upstream of the shifter in normalize/denormalize paths.

## Interface
- `WIDTH`, default 4: data width, ≥2.
- `SW`, default `$clog2(WIDTH)`: shift-count width.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `in_valid`, in, 1: input word offered.
- `in_ready`, out, 1: block can accept. Combinational, equal to state==IDLE.
- `in_data`, in, WIDTH: word to normalize.
- `in_dir`, in, 1: 0 = normalize left (MSB), 1 = normalize right (LSB).
- `out_valid`, out, 1: result held stable.
- `out_ready`, in, 1: consumer accepts result.
- `out_data`, out, WIDTH: normalized word.
- `out_shift`, out, SW: number of bit positions shifted.
- `out_dir`, out, 1: registered copy of `in_dir`.
- `out_zero`, out, 1: input word was all zeros.

## Operation
- **FSM states:** IDLE, SHIFT, DONE. Reset forces IDLE.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_shift`=0, `out_dir`=0, `out_zero`=0. `in_ready`=1 whenever the state is IDLE, including during reset.
- **IDLE:** on `in_valid & in_ready`, load `in_data` into the work register, clear the count, latch `in_dir`, go to SHIFT.
- **SHIFT, checks in priority order:**
  - Work register == 0: set `out_zero`=1, `out_data`=0, `out_shift`=0, go to DONE.
  - Target bit set (MSB if dir=0, LSB if dir=1): copy the work register and count to the outputs, `out_zero`=0, go to DONE.
  - Otherwise: shift the work register one bit (left if dir=0, right if dir=1, zero fill), increment the count, stay in SHIFT.
- **DONE:** `out_valid`=1, outputs frozen. On `out_ready`, clear `out_valid` and go to IDLE. No new input is accepted in the same cycle.
- **Shift count:** never exceeds WIDTH-1, so it cannot wrap.
- **Input signals while not in IDLE:** `in_data`/`in_dir` are ignored; `in_valid` held high is accepted on the first IDLE cycle.
- **Reset mid-operation:** asserting `rst` in any state aborts immediately. Outputs return to their reset values, the state returns to IDLE, and no partial result is presented.

## Timing
- Accept edge is T.
- **Iterative mode:** for a nonzero input needing k shifts, `out_valid` rises after edge T+k+1. For a zero input it rises after T+1. Worst-case latency is WIDTH cycles.
- `out_valid` is held until the `out_ready` edge and falls after that edge. `in_ready` returns high in the following cycle.
- **Minimum cycle:** one transaction per k+3 cycles (accept, k+1 in SHIFT, DONE with `out_ready` high).
- **Outputs:** `out_*` are registers, with no combinational path from inputs.

## Configuration
- `SHIFT_NORM_FAST_EN` defined: SHIFT resolves in a single cycle using a priority encoder (leading-one for dir=0, trailing-one for dir=1) and a one-step barrel shift. `out_valid` rises after T+1 for every input, including zero. Results are bit-identical to iterative mode.
- Undefined: iterative one-bit-per-cycle operation as described above.

## Test plan
- **Left normalize:** dir=0, `in_data`=4'b0010 → `out_data`=4'b1000, `out_shift`=2, `out_zero`=0. `out_valid` after T+3 (iterative) or T+1 (fast).
- **Right normalize:** dir=1, `in_data`=4'b1100 → `out_data`=4'b0011, `out_shift`=2. Also dir=1, 4'b0001 → 4'b0001, shift 0, `out_valid` after T+1.
- **Zero input:** dir=0, `in_data`=0 → `out_zero`=1, `out_data`=0, `out_shift`=0, `out_valid` after T+1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid`. Outputs stay stable, `in_ready`=0, and a changing `in_data` is ignored. Release → IDLE next cycle, and the next word is accepted.
- **Reset mid-shift:** dir=0, 4'b0001, assert `rst` one cycle after accept → all outputs 0, `in_ready`=1, and no `out_valid` pulse after deassert.
- **Round trip:** all 16 values × both dirs. Feed `out_data`/`out_shift` into the barrel shifter with the opposite dir → result equals `in_data`.
